// File: rtl/mtr_drv_ctrl.sv
// Dual-channel motor drive controller: PWM period timing, slew-limited duty ramping
// with direction changes through zero, and latched overcurrent fault handling.
module mtr_drv_ctrl #(
    parameter logic [10:0] MIN_DUTY   = 11'h080,
    parameter logic [10:0] MAX_STEP   = 11'h040,
    parameter int          OC_PERIODS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [11:0] lft_spd_i,
    input  logic [11:0] rght_spd_i,
    input  logic        spd_vld_i,
    input  logic        ovr_I_i,
    output logic [10:0] lft_duty_o,
    output logic [10:0] rght_duty_o,
    output logic        lft_rev_o,
    output logic        rght_rev_o,
    output logic        prd_strt_o,
    output logic        fault_o,
    output logic [1:0]  state_o
);

    localparam int OCW = $clog2(OC_PERIODS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [10:0]     cnt_q, cnt_d;
    logic [11:0]     lh_q, lh_d, rh_q, rh_d;
    logic [OCW-1:0]  oc_q, oc_d;
    logic [10:0]     lduty_q, lduty_d, rduty_q, rduty_d;
    logic            lrev_q, lrev_d, rrev_q, rrev_d;
    logic            fault_q, fault_d;
    logic            boundary;

    // Returns {rev, duty} for one channel after one boundary of slewing.
    function automatic logic [11:0] slew_ch(input logic [11:0] spd,
                                            input logic [10:0] duty,
                                            input logic        rev);
        logic        dir;
        logic [12:0] mag;
        logic [12:0] sum;
        logic [10:0] tgt;
        logic [11:0] up;
        logic [11:0] dn;
        logic        nrev;
        logic [10:0] nduty;
        dir   = spd[11];
        mag   = dir ? (13'd0 - {spd[11], spd}) : {1'b0, spd};
        sum   = mag + {2'b00, MIN_DUTY};
        tgt   = (spd == 12'd0) ? 11'h000 : ((sum > 13'h07FF) ? 11'h7FF : sum[10:0]);
        nrev  = rev;
        nduty = duty;
        if (dir != rev && duty == 11'h000) begin
            nrev = dir;
        end else begin
            // Opposite direction requested: ramp down to zero before the flip.
            if (dir != rev) tgt = 11'h000;
            up = {1'b0, duty} + {1'b0, MAX_STEP};
            dn = {1'b0, duty} - {1'b0, tgt};
            if (tgt > duty)
                nduty = (up > {1'b0, tgt}) ? tgt : up[10:0];
            else if (tgt < duty)
                nduty = (dn > {1'b0, MAX_STEP}) ? (duty - MAX_STEP) : tgt;
        end
        return {nrev, nduty};
    endfunction

    assign boundary = (cnt_q == 11'h7FF);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 11'd1;
        lh_d    = lh_q;
        rh_d    = rh_q;
        oc_d    = oc_q;
        lduty_d = lduty_q;
        rduty_d = rduty_q;
        lrev_d  = lrev_q;
        rrev_d  = rrev_q;
        fault_d = fault_q;
        if (spd_vld_i) begin
            lh_d = lft_spd_i;
            rh_d = rght_spd_i;
        end
        if (boundary) begin
            case (state_q)
                S_IDLE: begin
                    if (en_i && !ovr_I_i) state_d = S_RUN;
                end
                S_RUN: begin
                    if (!en_i) begin
                        state_d = S_IDLE;
                        oc_d    = '0;
                        lduty_d = '0;
                        rduty_d = '0;
                        lrev_d  = 1'b0;
                        rrev_d  = 1'b0;
                    end else if (ovr_I_i && (int'(oc_q) + 1 >= OC_PERIODS)) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        oc_d    = '0;
                        lduty_d = '0;
                        rduty_d = '0;
                    end else begin
                        oc_d = ovr_I_i ? (oc_q + OCW'(1)) : '0;
                        {lrev_d, lduty_d} = slew_ch(lh_q, lduty_q, lrev_q);
                        {rrev_d, rduty_d} = slew_ch(rh_q, rduty_q, rrev_q);
                    end
                end
                S_FAULT: begin
                    if (!en_i) begin
                        state_d = S_IDLE;
                        fault_d = 1'b0;
                        lrev_d  = 1'b0;
                        rrev_d  = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lh_q    <= '0;
            rh_q    <= '0;
            oc_q    <= '0;
            lduty_q <= '0;
            rduty_q <= '0;
            lrev_q  <= 1'b0;
            rrev_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lh_q    <= lh_d;
            rh_q    <= rh_d;
            oc_q    <= oc_d;
            lduty_q <= lduty_d;
            rduty_q <= rduty_d;
            lrev_q  <= lrev_d;
            rrev_q  <= rrev_d;
            fault_q <= fault_d;
        end
    end

    // Counter sits at 0 throughout reset; the pulse is held off until release.
    assign prd_strt_o  = (cnt_q == 11'h000) && !rst_i;
    assign lft_duty_o  = lduty_q;
    assign rght_duty_o = rduty_q;
    assign lft_rev_o   = lrev_q;
    assign rght_rev_o  = rrev_q;
    assign fault_o     = fault_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mtr_drv_ctrl.sv
// Bench for mtr_drv_ctrl: per-feature scenario tasks checked against a
// boundary-level behavioural model of the drive rules.
module tb_mtr_drv_ctrl;
    localparam logic [10:0] MIN_DUTY   = 11'h080;
    localparam logic [10:0] MAX_STEP   = 11'h100;
    localparam int          OC_PERIODS = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_FAULT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i, en_i, spd_vld_i, ovr_I_i;
    logic [11:0] lft_spd_i, rght_spd_i;
    logic [10:0] lft_duty_o, rght_duty_o;
    logic        lft_rev_o, rght_rev_o, prd_strt_o, fault_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errs   = 0;
    int phase;
    int m_mode, m_oc, m_fault;
    int m_hold[2];
    int m_duty[2];
    int m_rev[2];

    always #10 clk_i = ~clk_i;

    mtr_drv_ctrl #(.MIN_DUTY(MIN_DUTY), .MAX_STEP(MAX_STEP), .OC_PERIODS(OC_PERIODS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .lft_spd_i(lft_spd_i), .rght_spd_i(rght_spd_i), .spd_vld_i(spd_vld_i),
        .ovr_I_i(ovr_I_i),
        .lft_duty_o(lft_duty_o), .rght_duty_o(rght_duty_o),
        .lft_rev_o(lft_rev_o), .rght_rev_o(rght_rev_o),
        .prd_strt_o(prd_strt_o), .fault_o(fault_o), .state_o(state_o)
    );

    function automatic int target_of(int s);
        int t;
        if (s == 0) return 0;
        t = (s < 0 ? -s : s) + int'(MIN_DUTY);
        return (t > 2047) ? 2047 : t;
    endfunction

    function automatic void model_reset();
        phase = 0; m_mode = M_IDLE; m_oc = 0; m_fault = 0;
        for (int c = 0; c < 2; c++) begin
            m_hold[c] = 0; m_duty[c] = 0; m_rev[c] = 0;
        end
    endfunction

    function automatic void model_boundary(bit en, bit ovr);
        int goal, dir;
        case (m_mode)
            M_IDLE: if (en && !ovr) m_mode = M_RUN;
            M_RUN: begin
                if (!en) begin
                    m_mode = M_IDLE; m_oc = 0;
                    for (int c = 0; c < 2; c++) begin m_duty[c] = 0; m_rev[c] = 0; end
                end else begin
                    m_oc = ovr ? m_oc + 1 : 0;
                    if (m_oc >= OC_PERIODS) begin
                        m_mode = M_FAULT; m_fault = 1; m_oc = 0;
                        m_duty[0] = 0; m_duty[1] = 0;
                    end else begin
                        for (int c = 0; c < 2; c++) begin
                            dir  = (m_hold[c] < 0) ? 1 : 0;
                            goal = target_of(m_hold[c]);
                            if (dir != m_rev[c]) begin
                                if (m_duty[c] == 0) m_rev[c] = dir;
                                goal = 0;
                            end
                            if (goal > m_duty[c])
                                m_duty[c] = (m_duty[c] + int'(MAX_STEP) > goal) ? goal : m_duty[c] + int'(MAX_STEP);
                            else
                                m_duty[c] = (m_duty[c] - int'(MAX_STEP) < goal) ? goal : m_duty[c] - int'(MAX_STEP);
                        end
                    end
                end
            end
            default: if (!en) begin m_mode = M_IDLE; m_fault = 0; m_rev[0] = 0; m_rev[1] = 0; end
        endcase
    endfunction

    function automatic logic [26:0] exp_vec();
        return {11'(m_duty[0]), m_rev[0] != 0, 11'(m_duty[1]), m_rev[1] != 0, m_fault != 0, 2'(m_mode)};
    endfunction

    function automatic logic [26:0] act_vec();
        return {lft_duty_o, lft_rev_o, rght_duty_o, rght_rev_o, fault_o, state_o};
    endfunction

    task automatic tick();
        bit bnd, en_c, ovr_c, vld_c;
        int l_c, r_c;
        bnd = (phase == 2047);
        en_c = en_i; ovr_c = ovr_I_i; vld_c = spd_vld_i;
        l_c = int'($signed(lft_spd_i));
        r_c = int'($signed(rght_spd_i));
        @(posedge clk_i);
        if (bnd) model_boundary(en_c, ovr_c);
        if (vld_c) begin m_hold[0] = l_c; m_hold[1] = r_c; end
        phase = (phase + 1) % 2048;
        #1;
    endtask

    task automatic strobe(input logic [11:0] l, input logic [11:0] r);
        lft_spd_i = l; rght_spd_i = r; spd_vld_i = 1'b1;
        tick();
        spd_vld_i = 1'b0;
    endtask

    task automatic adv_boundary();
        do tick(); while (phase != 0);
    endtask

    function automatic logic [11:0] rand_spd();
        case ($urandom_range(0, 4))
            0: return 12'h000;
            1: return 12'h800;
            2: return 12'h7FF;
            3: return 12'($signed($urandom_range(0, 400)) - 200);
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b0; spd_vld_i = 1'b0; ovr_I_i = 1'b0;
        lft_spd_i = '0; rght_spd_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({act_vec(), prd_strt_o} !== 28'd0) begin
            errs++; $display("FAIL reset_outputs: got %h expected 0", {act_vec(), prd_strt_o});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if (prd_strt_o !== 1'b1) begin
            errs++; $display("FAIL first_prd_strt: got %b expected 1", prd_strt_o);
        end
        checks++;
        if (act_vec() !== exp_vec()) begin
            errs++; $display("FAIL post_reset_state: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_period();
        int bad = 0, pulses = 0, last = -1, gap_bad = 0;
        strobe(12'd300, 12'hF00);
        for (int i = 1; i <= 4095; i++) begin
            tick();
            if (prd_strt_o !== (phase == 0)) bad++;
            if (act_vec() !== exp_vec()) bad++;
            if (prd_strt_o === 1'b1) begin
                if (last >= 0 && i - last != 2048) gap_bad++;
                last = i; pulses++;
            end
        end
        checks++;
        if (bad != 0) begin errs++; $display("FAIL idle_period_cycles: got %0d bad cycles expected 0", bad); end
        checks++;
        if (pulses != 2) begin errs++; $display("FAIL prd_strt_count: got %0d expected 2", pulses); end
        checks++;
        if (gap_bad != 0) begin errs++; $display("FAIL prd_strt_gap: got %0d bad gaps expected 0", gap_bad); end
    endtask

    task automatic test_ramp();
        en_i = 1'b1;
        strobe(12'd256, 12'h800);
        adv_boundary();
        checks++;
        if (act_vec() !== exp_vec() || state_o !== 2'(M_RUN)) begin
            errs++; $display("FAIL run_entry: got %h expected %h", act_vec(), exp_vec());
        end
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) strobe(12'd128, 12'h800);
            if (k == 5) strobe(12'hFC0, 12'h800);
            adv_boundary();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errs++; $display("FAIL ramp_step_%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
            if (k == 2) begin
                checks++;
                if (lft_duty_o !== 11'h180 || rght_duty_o !== 11'h100 || rght_rev_o !== 1'b1) begin
                    errs++; $display("FAIL ramp_k2: got %h/%h expected 180/100", lft_duty_o, rght_duty_o);
                end
            end
        end
        repeat (1000) tick();
        checks++;
        if ({lft_duty_o, lft_rev_o, rght_duty_o, rght_rev_o} !== {11'h0C0, 1'b1, 11'h7FF, 1'b1}) begin
            errs++; $display("FAIL ramp_final: got %h/%b %h/%b expected 0c0/1 7ff/1",
                             lft_duty_o, lft_rev_o, rght_duty_o, rght_rev_o);
        end
    endtask

    task automatic test_overcurrent();
        ovr_I_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adv_boundary();
            checks++;
            if (act_vec() !== exp_vec() || fault_o !== 1'b0) begin
                errs++; $display("FAIL oc_short_%0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        ovr_I_i = 1'b0;
        adv_boundary();
        ovr_I_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            adv_boundary();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errs++; $display("FAIL oc_long_%0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if ({fault_o, lft_duty_o, rght_duty_o, lft_rev_o, rght_rev_o, state_o} !== {1'b1, 22'd0, 2'b11, 2'(M_FAULT)}) begin
            errs++; $display("FAIL oc_trip: got %h expected fault with zero duty", act_vec());
        end
        adv_boundary();
        ovr_I_i = 1'b0;
        adv_boundary();
        checks++;
        if (fault_o !== 1'b1 || state_o !== 2'(M_FAULT)) begin
            errs++; $display("FAIL fault_hold: got %b/%0d expected 1/%0d", fault_o, state_o, M_FAULT);
        end
        en_i = 1'b0;
        adv_boundary();
        checks++;
        if (act_vec() !== exp_vec() || act_vec() !== 27'd0) begin
            errs++; $display("FAIL fault_exit: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        en_i = 1'b1;
        strobe(12'd64, 12'd0);
        adv_boundary();
        adv_boundary();
        checks++;
        if (lft_duty_o !== 11'h0C0 || act_vec() !== exp_vec()) begin
            errs++; $display("FAIL pre_reset_duty: got %h expected 0c0", lft_duty_o);
        end
        repeat (700) tick();
        #4;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({act_vec(), prd_strt_o} !== 28'd0) begin
            errs++; $display("FAIL async_reset: got %h expected 0", {act_vec(), prd_strt_o});
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if (prd_strt_o !== 1'b1 || state_o !== 2'(M_IDLE)) begin
            errs++; $display("FAIL reset_release: got prd %b state %0d expected 1/%0d", prd_strt_o, state_o, M_IDLE);
        end
    endtask

    task automatic test_boundary_strobe();
        adv_boundary();
        while (phase != 2047) tick();
        strobe(12'd256, 12'd0);
        checks++;
        if (lft_duty_o !== 11'h000 || prd_strt_o !== 1'b1 || act_vec() !== exp_vec()) begin
            errs++; $display("FAIL strobe_on_boundary: got %h prd %b expected 000 prd 1", lft_duty_o, prd_strt_o);
        end
        adv_boundary();
        checks++;
        if (lft_duty_o !== 11'h100 || act_vec() !== exp_vec()) begin
            errs++; $display("FAIL strobe_applied_next: got %h expected 100", lft_duty_o);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            en_i    = ($urandom_range(0, 7) != 0);
            ovr_I_i = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(10, 1500)) tick();
            strobe(rand_spd(), rand_spd());
            if ($urandom_range(0, 2) == 0) begin
                while (phase != 2047) tick();
                strobe(rand_spd(), rand_spd());
            end
            adv_boundary();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errs++; $display("FAIL random_%0d: got %h expected %h", p, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_period();
        test_ramp();
        test_overcurrent();
        test_reset_mid();
        test_boundary_strobe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
